// File: rtl/seq_pkg.sv
// Shared types for the result collector: FSM state encoding, default counter
// width and the summary record carried by the output buffer.
package seq_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } coll_state_e;

  // Summary of one burst; count fields sized for the widest supported CNT_W.
  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] hits;
    logic [CNT_W_DEFAULT-1:0] total;
    logic [CNT_W_DEFAULT-1:0] max_run;
    logic                     all_hit;
  } seq_summary_t;

endpackage : seq_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr (sync clear, wins over inc),
//        inc (count up by one, holds at all-ones), count (registered value).
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/seq_result_collector.sv
// Collects bursts of 1-bit detector results into summary records
// (hits, total, longest hit run, all-hit flag) presented on a valid/ready
// port backed by a one-entry buffer. A record arriving while the buffer is
// still held is dropped and flagged on the sticky drop_err.
// Ports: clk, rst (sync, active-high); in_valid/in_data result stream;
//        out_ready from downstream; out_valid, out_hits, out_total,
//        out_max_run, out_all record outputs; drop_err sticky loss flag.
// CNT_W must not exceed seq_pkg::CNT_W_DEFAULT.
module seq_result_collector
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_hits,
  output logic [CNT_W-1:0] out_total,
  output logic [CNT_W-1:0] out_max_run,
  output logic             out_all,
  output logic             drop_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  coll_state_e      state, state_nxt;
  logic             burst_end_c;
  logic             hit_c, miss_c;
  logic [CNT_W-1:0] total_cnt, hits_cnt, cur_run;
  logic [CNT_W-1:0] run_next_c;
  logic [CNT_W-1:0] max_run;
  logic             all_flag;
  seq_summary_t     new_rec_c;
  seq_summary_t     out_rec;

  assign hit_c  = in_valid && in_data;
  assign miss_c = in_valid && !in_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; a burst ends on the first idle cycle seen in COLLECT
  always_comb begin
    state_nxt   = state;
    burst_end_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (!in_valid) begin
          state_nxt   = IDLE;
          burst_end_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_total (
    .clk(clk), .rst(rst), .clr(burst_end_c), .inc(in_valid), .count(total_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hits (
    .clk(clk), .rst(rst), .clr(burst_end_c), .inc(hit_c), .count(hits_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cur_run (
    .clk(clk), .rst(rst), .clr(burst_end_c || miss_c), .inc(hit_c), .count(cur_run)
  );

  // Run length this hit would produce, saturated like the counter itself
  assign run_next_c = (cur_run == CNT_MAX) ? cur_run : cur_run + CNT_W'(1);

  // Longest run and all-hit tracking for the burst in progress
  always_ff @(posedge clk) begin
    if (rst || burst_end_c) begin
      max_run  <= '0;
      all_flag <= 1'b1;
    end else begin
      if (hit_c && (run_next_c > max_run)) max_run <= run_next_c;
      if (miss_c) all_flag <= 1'b0;
    end
  end

  always_comb begin
    new_rec_c         = '0;
    new_rec_c.hits    = CNT_W_DEFAULT'(hits_cnt);
    new_rec_c.total   = CNT_W_DEFAULT'(total_cnt);
    new_rec_c.max_run = CNT_W_DEFAULT'(max_run);
    new_rec_c.all_hit = all_flag && (total_cnt != '0);
  end

  // One-entry output buffer; a completing burst may replace a record that is
  // being accepted on the same edge, otherwise it is lost while one is held
  always_ff @(posedge clk) begin
    if (rst) begin
      out_rec   <= '0;
      out_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else if (burst_end_c) begin
      if (!out_valid || out_ready) begin
        out_rec   <= new_rec_c;
        out_valid <= 1'b1;
      end else begin
        drop_err  <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_hits    = CNT_W'(out_rec.hits);
  assign out_total   = CNT_W'(out_rec.total);
  assign out_max_run = CNT_W'(out_rec.max_run);
  assign out_all     = out_rec.all_hit;

endmodule : seq_result_collector
